memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-core RAM arbiter sitting between the per-core icache/dcache request ports and the single shared RAM port. It serialises up to 2*CPUS requesters onto RAM with a registered grant, round-robin between cores, and dcache-before-icache priority within a core. It holds the grant until RAM reports ACCESS, then returns the data and a one-cycle wait release to the owner only. It is the multi-core replacement for the single-core combinational memory controller and is the anchor point for the later coherence logic.

## Interface
- CPUS, 2: number of cores; the design supports exactly 2, and an elaboration error fires for any other value.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  CPUS  per-core instruction read request.
- dREN  in  CPUS  per-core data read request.
- dWEN  in  CPUS  per-core data write request; dREN and dWEN are never both high on one core.
- iaddr  in  CPUS x word_t  per-core instruction address.
- daddr  in  CPUS x word_t  per-core data address.
- dstore  in  CPUS x word_t  per-core write data.
- ramload  in  word_t  RAM read data.
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.
- iwait  out  CPUS  instruction wait; 1 = stall.
- dwait  out  CPUS  data wait; 1 = stall.
- iload  out  CPUS x word_t  instruction read data.
- dload  out  CPUS x word_t  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  word_t  RAM address.
- ramstore  out  word_t  RAM write data.

## Operation
- States: IDLE and OWNED. Registered state: owner core (1 bit), owner type (I, DR, DW), last-served core ptr, latched addr and store word.
- IDLE:
  - Scan cores starting at ptr, then ptr+1 mod CPUS.
  - Within a core, the order is dWEN, then dREN, then iREN.
  - On the first hit: latch owner, type, address and store data, then go to OWNED at the next edge.
  - No hit: stay in IDLE.
- OWNED:
  - Drive ramaddr and ramstore from the latched values.
  - ramREN = 1 for types I and DR; ramWEN = 1 for DW.
- ramstate == ACCESS while OWNED:
  - Deassert the owner's wait combinationally in that cycle.
  - Drive the owner's load with ramload (reads only).
  - Next edge: go to IDLE, ptr <= other core.
- ramstate == BUSY, FREE or ERROR while OWNED: hold the grant. ERROR is retried indefinitely and never releases wait.
- Abandon: if the owner's originating request bit deasserts while OWNED, go to IDLE at the next edge with no wait release and ptr unchanged.
  - If ACCESS arrives in that same cycle, the abandon wins and no wait release occurs.
- Non-owners: wait = 1 and load = 0 at all times.
- In IDLE: ramREN = ramWEN = 0, ramaddr = ramstore = 0.

## Timing
- Reset values (asynchronous):
  - State IDLE, ptr = 0, latches cleared.
  - All iwait/dwait = 1, all loads = 0.
  - ramREN = ramWEN = 0, ramaddr = ramstore = 0.
- Reset mid-transaction drops the grant immediately. RAM enables fall asynchronously with nRST low.
- A request is sampled in IDLE cycle N; RAM enables assert in cycle N+1.
- Minimum latency is 2 cycles, request to wait low, when ACCESS arrives in N+1.
- At least one IDLE cycle separates consecutive grants, so peak throughput is one access per 2 cycles.
- The wait release lasts exactly one cycle per grant.
- The address/data latches make the RAM port stable for the whole grant, even if the requester changes iaddr or daddr mid-grant.

## Structure
- Add arb_state_t (IDLE, OWNED) and req_type_t (REQ_I, REQ_DR, REQ_DW) to cpu_types_pkg. word_t and ramstate_t already live there.
- One sub-module, rr_select:
  - Combinational fixed-width round-robin picker.
  - Inputs: per-core request-valid and ptr.
  - Outputs: grant-valid and granted core index.
- The intra-core dWEN > dREN > iREN priority stays in memory_arbiter.

## Test plan
- Single read: core0 iREN, iaddr = 0x100; ramstate ACCESS one cycle after the grant, ramload = 0xDEADBEEF.
  - Required: iwait[0] low for exactly 1 cycle with iload[0] = 0xDEADBEEF; ramREN high for 1 cycle.
- Intra-core priority: core1 dWEN (daddr = 0x200, dstore = 0x12345678) and iREN asserted together.
  - Required: the write goes first (ramWEN, ramaddr = 0x200, ramstore = 0x12345678).
  - Then the instruction fetch follows, after a core0 slot only if core0 is requesting.
- Round-robin: both cores hold dREN continuously with ramstate ACCESS every OWNED cycle.
  - Required: grants alternate 0,1,0,1; each dwait pulses once every 4 cycles.
- Latched address: core0 changes daddr from 0x40 to 0x80 mid-grant with ramstate BUSY for 3 cycles.
  - Required: ramaddr stays 0x40 until the ACCESS cycle.
- Abandon and reset:
  - Owner drops dREN while BUSY. Required: IDLE next cycle, no dwait pulse, ptr unchanged.
  - nRST asserted mid-grant. Required: all waits = 1 and ramREN = 0 immediately.
- ERROR hold: ramstate ERROR for 5 cycles, then ACCESS.
  - Required: wait stays high for the 5 ERROR cycles and releases only in the ACCESS cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus words, RAM status
// and the memory arbiter's state/request encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_I,
    REQ_DR,
    REQ_DW
  } req_type_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter.
// slave is the arbiter's view, master the cores/RAM view.
interface memory_arbiter_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  logic [CPUS-1:0] iREN;
  logic [CPUS-1:0] dREN;
  logic [CPUS-1:0] dWEN;
  word_t [CPUS-1:0] iaddr;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0] iwait;
  logic [CPUS-1:0] dwait;
  word_t [CPUS-1:0] iload;
  word_t [CPUS-1:0] dload;

  word_t     ramload;
  ramstate_t ramstate;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;

  modport slave (
    input  iREN, dREN, dWEN,
    input  iaddr, daddr, dstore,
    input  ramload, ramstate,
    output iwait, dwait, iload, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, dREN, dWEN,
    output iaddr, daddr, dstore,
    output ramload, ramstate,
    input  iwait, dwait, iload, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_rr_select.sv
// Two-way round-robin picker: the pointed-to core
// wins when requesting, otherwise the other one.
module rr_select (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  // favour ptr, fall back to the other core
  always_comb begin
    gnt_vld = |req;
    gnt_idx = ptr;
    if (!req[ptr]) gnt_idx = ~ptr;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-core RAM arbiter: registered round-robin grant,
// dcache before icache, held until RAM reports ACCESS.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input logic CLK,
  input logic nRST,
  memory_arbiter_if.slave bus
);

  if (CPUS != 2) begin : g_cpus_chk
    $error("memory_arbiter supports exactly 2 cores");
  end

  arb_state_t state, state_n;
  req_type_t  otype, otype_n;
  logic       owner, owner_n;
  logic       ptr, ptr_n;
  word_t      addr_q, addr_n;
  word_t      store_q, store_n;

  logic [1:0] vld;
  logic       gnt_vld;
  logic       gnt_idx;
  logic       owned;
  logic       orig;
  logic       ack;

  logic [1:0] iwait, dwait;
  word_t [1:0] iload, dload;

  assign vld = bus.iREN | bus.dREN | bus.dWEN;

  rr_select u_rr (
    .req     (vld),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // gating with nRST drops RAM enables as soon as reset asserts
  assign owned = (state == OWNED) && nRST;
  assign ack   = owned && orig && (bus.ramstate == ACCESS);

  // request bit that created the current grant
  always_comb begin
    orig = 1'b0;
    unique case (otype)
      REQ_I:   orig = bus.iREN[owner];
      REQ_DR:  orig = bus.dREN[owner];
      REQ_DW:  orig = bus.dWEN[owner];
      default: orig = 1'b0;
    endcase
  end

  // state register and grant latches
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      otype   <= REQ_I;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state   <= state_n;
      otype   <= otype_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      addr_q  <= addr_n;
      store_q <= store_n;
    end
  end

  // next grant: rr across cores, dWEN > dREN > iREN inside one
  always_comb begin
    state_n = state;
    otype_n = otype;
    owner_n = owner;
    ptr_n   = ptr;
    addr_n  = addr_q;
    store_n = store_q;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_n = OWNED;
          owner_n = gnt_idx;
          store_n = '0;
          unique case (1'b1)
            bus.dWEN[gnt_idx]: begin
              otype_n = REQ_DW;
              addr_n  = bus.daddr[gnt_idx];
              store_n = bus.dstore[gnt_idx];
            end
            bus.dREN[gnt_idx]: begin
              otype_n = REQ_DR;
              addr_n  = bus.daddr[gnt_idx];
            end
            default: begin
              otype_n = REQ_I;
              addr_n  = bus.iaddr[gnt_idx];
            end
          endcase
        end
      end
      OWNED: begin
        if (!orig) begin
          state_n = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          state_n = IDLE;
          ptr_n   = ~owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM port drive and owner-only wait release
  always_comb begin
    iwait      = '1;
    dwait      = '1;
    iload      = '0;
    dload      = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (owned) begin
      bus.ramaddr  = addr_q;
      bus.ramstore = store_q;
      bus.ramREN   = (otype != REQ_DW);
      bus.ramWEN   = (otype == REQ_DW);
    end
    if (ack) begin
      unique case (otype)
        REQ_I: begin
          iwait[owner] = 1'b0;
          iload[owner] = bus.ramload;
        end
        REQ_DR: begin
          dwait[owner] = 1'b0;
          dload[owner] = bus.ramload;
        end
        default: dwait[owner] = 1'b0;
      endcase
    end
  end

  assign bus.iwait = iwait;
  assign bus.dwait = dwait;
  assign bus.iload = iload;
  assign bus.dload = dload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: expected wait
// releases are queued at stimulus time, popped on release.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if #(.CPUS(2)) bus ();

  memory_arbiter #(.CPUS(2)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  typedef struct {
    int    core;
    bit    is_i;
    word_t data;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int ipulse[2] = '{0, 0};
  int dpulse[2] = '{0, 0};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic on_release(int c, bit is_i, word_t data);
    exp_t e;
    if (sb.size() == 0) begin
      check("spurious_release", 64'(c + 1), 64'd0);
    end else begin
      e = sb.pop_front();
      check("rel_core", 64'(c), 64'(e.core));
      check("rel_chan", 64'(is_i), 64'(e.is_i));
      check("rel_data", 64'(data), 64'(e.data));
    end
  endtask

  // watch every wait line and match releases to the scoreboard
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!bus.iwait[c]) begin
        ipulse[c]++;
        on_release(c, 1'b1, bus.iload[c]);
      end
      if (!bus.dwait[c]) begin
        dpulse[c]++;
        on_release(c, 1'b0, bus.dload[c]);
      end
    end
  end

  initial begin
    bus.iREN = '0;
    bus.dREN = '0;
    bus.dWEN = '0;
    bus.iaddr = '0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.ramload = '0;
    bus.ramstate = FREE;

    repeat (2) @(posedge clk);
    samp();
    check("rst_iwait", 64'(bus.iwait), 64'd3);
    check("rst_dwait", 64'(bus.dwait), 64'd3);
    check("rst_ren", 64'(bus.ramREN), 64'd0);
    check("rst_wen", 64'(bus.ramWEN), 64'd0);
    check("rst_addr", 64'(bus.ramaddr), 64'd0);
    check("rst_iload", 64'(bus.iload), 64'd0);
    tick();
    rst_n = 1'b1;

    // single read
    bus.iREN[0] = 1'b1;
    bus.iaddr[0] = 32'h100;
    samp();
    check("t1_idle_ren", 64'(bus.ramREN), 64'd0);
    check("t1_idle_iwait", 64'(bus.iwait), 64'd3);
    tick();
    bus.ramstate = ACCESS;
    bus.ramload = 32'hDEADBEEF;
    sb.push_back('{0, 1'b1, 32'hDEADBEEF});
    samp();
    check("t1_ren", 64'(bus.ramREN), 64'd1);
    check("t1_addr", 64'(bus.ramaddr), 64'h100);
    check("t1_iwait", 64'(bus.iwait[0]), 64'd0);
    tick();
    bus.iREN[0] = 1'b0;
    bus.ramstate = FREE;
    samp();
    check("t1_ren_off", 64'(bus.ramREN), 64'd0);
    check("t1_iwait_hi", 64'(bus.iwait[0]), 64'd1);
    tick();

    // intra-core priority: write before fetch
    bus.dWEN[1] = 1'b1;
    bus.iREN[1] = 1'b1;
    bus.daddr[1] = 32'h200;
    bus.dstore[1] = 32'h12345678;
    bus.iaddr[1] = 32'h300;
    tick();
    bus.ramstate = ACCESS;
    sb.push_back('{1, 1'b0, 32'h0});
    samp();
    check("t2_wen", 64'(bus.ramWEN), 64'd1);
    check("t2_ren", 64'(bus.ramREN), 64'd0);
    check("t2_addr", 64'(bus.ramaddr), 64'h200);
    check("t2_store", 64'(bus.ramstore), 64'h12345678);
    tick();
    bus.dWEN[1] = 1'b0;
    bus.ramstate = FREE;
    tick();
    bus.ramstate = ACCESS;
    bus.ramload = 32'hCAFEF00D;
    sb.push_back('{1, 1'b1, 32'hCAFEF00D});
    samp();
    check("t2_i_ren", 64'(bus.ramREN), 64'd1);
    check("t2_i_addr", 64'(bus.ramaddr), 64'h300);
    tick();
    bus.iREN[1] = 1'b0;
    bus.ramstate = FREE;
    samp();
    check("t2_ren_off", 64'(bus.ramREN), 64'd0);
    tick();

    // round-robin with both cores reading
    bus.dREN = 2'b11;
    bus.daddr[0] = 32'h10;
    bus.daddr[1] = 32'h20;
    bus.ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      bus.ramload = 32'hA000 + 32'(k);
      if (k % 2 == 1)
        sb.push_back('{(k / 2) % 2, 1'b0, 32'hA000 + 32'(k)});
      samp();
      if (k % 2 == 1)
        check("rr_addr", 64'(bus.ramaddr),
              ((k / 2) % 2 == 1) ? 64'h20 : 64'h10);
      else
        check("rr_idle", 64'(bus.ramREN), 64'd0);
      tick();
    end
    bus.dREN = '0;
    bus.ramstate = FREE;
    samp();
    check("rr_ren_off", 64'(bus.ramREN), 64'd0);
    tick();

    // latched address across BUSY
    bus.dREN[0] = 1'b1;
    bus.daddr[0] = 32'h40;
    tick();
    bus.daddr[0] = 32'h80;
    bus.ramstate = BUSY;
    for (int k = 0; k < 3; k++) begin
      samp();
      check("lat_addr", 64'(bus.ramaddr), 64'h40);
      check("lat_dwait", 64'(bus.dwait[0]), 64'd1);
      tick();
    end
    bus.ramstate = ACCESS;
    bus.ramload = 32'h55AA;
    sb.push_back('{0, 1'b0, 32'h55AA});
    samp();
    check("lat_addr_acc", 64'(bus.ramaddr), 64'h40);
    tick();
    bus.dREN[0] = 1'b0;
    bus.ramstate = FREE;
    tick();

    // abandon while BUSY, ptr must stay on core1
    bus.dREN[1] = 1'b1;
    bus.daddr[1] = 32'h60;
    tick();
    bus.ramstate = BUSY;
    samp();
    check("ab_ren", 64'(bus.ramREN), 64'd1);
    check("ab_addr", 64'(bus.ramaddr), 64'h60);
    tick();
    bus.dREN[1] = 1'b0;
    samp();
    check("ab_dwait", 64'(bus.dwait[1]), 64'd1);
    tick();
    bus.dREN = 2'b11;
    bus.daddr[0] = 32'h70;
    bus.daddr[1] = 32'h74;
    bus.ramstate = FREE;
    samp();
    check("ab_idle", 64'(bus.ramREN), 64'd0);
    tick();
    samp();
    check("ab_ptr", 64'(bus.ramaddr), 64'h74);
    tick();
    bus.dREN[1] = 1'b0;
    bus.ramstate = ACCESS;
    bus.ramload = 32'hBAD;
    samp();
    check("ab_acc_dwait", 64'(bus.dwait[1]), 64'd1);
    tick();
    bus.ramstate = FREE;
    samp();
    check("ab_acc_idle", 64'(bus.ramREN), 64'd0);
    tick();
    samp();
    check("c0_grant_ren", 64'(bus.ramREN), 64'd1);
    check("c0_grant_addr", 64'(bus.ramaddr), 64'h70);

    // reset mid-grant
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_iwait", 64'(bus.iwait), 64'd3);
    check("rst_mid_dwait", 64'(bus.dwait), 64'd3);
    check("rst_mid_ren", 64'(bus.ramREN), 64'd0);
    check("rst_mid_addr", 64'(bus.ramaddr), 64'd0);
    bus.dREN = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // ERROR retried, release only on ACCESS
    bus.iREN[0] = 1'b1;
    bus.iaddr[0] = 32'h500;
    tick();
    bus.ramstate = ERROR;
    for (int k = 0; k < 5; k++) begin
      samp();
      check("err_iwait", 64'(bus.iwait[0]), 64'd1);
      check("err_ren", 64'(bus.ramREN), 64'd1);
      tick();
    end
    bus.ramstate = ACCESS;
    bus.ramload = 32'h0E0E0E0E;
    sb.push_back('{0, 1'b1, 32'h0E0E0E0E});
    samp();
    check("err_release", 64'(bus.iwait[0]), 64'd0);
    tick();
    bus.iREN[0] = 1'b0;
    bus.ramstate = FREE;
    samp();
    check("err_ren_off", 64'(bus.ramREN), 64'd0);
    tick();

    check("pulses_i0", 64'(ipulse[0]), 64'd2);
    check("pulses_i1", 64'(ipulse[1]), 64'd1);
    check("pulses_d0", 64'(dpulse[0]), 64'd3);
    check("pulses_d1", 64'(dpulse[1]), 64'd3);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
